// File: rtl/button_updown_counter_pkg.sv
// Shared types and constants for the pushbutton up/down counter.
package button_updown_counter_pkg;

    localparam int DEFAULT_WIDTH           = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_UP   = 2'd1,
        CNT_DN   = 2'd2
    } cnt_op_e;

    // Bit width able to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/button_updown_counter_if.sv
// Button inputs and count/event outputs of the pushbutton up/down counter.
interface button_updown_counter_if
    import button_updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             btn_up;
    logic             btn_dn;
    logic [WIDTH-1:0] count;
    logic             up_evt;
    logic             dn_evt;
    logic             wrap;

    modport master (
        input  btn_up, btn_dn,
        output count, up_evt, dn_evt, wrap
    );

    modport slave (
        output btn_up, btn_dn,
        input  count, up_evt, dn_evt, wrap
    );

endinterface

// File: rtl/button_debounce.sv
// One pushbutton: 2-FF synchroniser, stability-counter debounce, registered
// single-cycle pulse on each accepted press (rising debounced level).
module button_debounce
    import button_updown_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    localparam int             CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             db;
    logic             db_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_d  <= db;
            evt   <= db & ~db_d;
            // Any return to the accepted level discards the partial count.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_updown_counter.sv
// Two debounced pushbuttons driving a WIDTH-bit up/down count with a
// wrap/clamp pulse; every output comes straight from a flop.
module button_updown_counter
    import button_updown_counter_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit SATURATE        = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    button_updown_counter_if.master bus
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic    up_pulse;
    logic    dn_pulse;
    cnt_op_e op;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk (clk),
        .rst (rst),
        .btn (bus.btn_up),
        .evt (up_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
        .clk (clk),
        .rst (rst),
        .btn (bus.btn_dn),
        .evt (dn_pulse)
    );

    // Simultaneous up and down presses cancel.
    always_comb begin
        op = CNT_HOLD;
        if (up_pulse && !dn_pulse) op = CNT_UP;
        if (dn_pulse && !up_pulse) op = CNT_DN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.count  <= '0;
            bus.up_evt <= 1'b0;
            bus.dn_evt <= 1'b0;
            bus.wrap   <= 1'b0;
        end else begin
            bus.up_evt <= up_pulse;
            bus.dn_evt <= dn_pulse;
            bus.wrap   <= 1'b0;
            case (op)
                CNT_UP: begin
                    if (bus.count == MAX_COUNT) begin
                        bus.wrap <= 1'b1;
                        if (!SATURATE) bus.count <= '0;
                    end else begin
                        bus.count <= bus.count + WIDTH'(1);
                    end
                end
                CNT_DN: begin
                    if (bus.count == '0) begin
                        bus.wrap <= 1'b1;
                        if (!SATURATE) bus.count <= MAX_COUNT;
                    end else begin
                        bus.count <= bus.count - WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_button_updown_counter.sv
// Bench for button_updown_counter: a wrapping and a saturating instance share
// the same buttons and are compared every cycle against a press-level model.
module tb_button_updown_counter;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    button_updown_counter_if #(.WIDTH(W)) bus_w ();
    button_updown_counter_if #(.WIDTH(W)) bus_s ();

    assign bus_w.btn_up = btn_up;
    assign bus_w.btn_dn = btn_dn;
    assign bus_s.btn_up = btn_up;
    assign bus_s.btn_dn = btn_dn;

    button_updown_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .SATURATE(1'b0)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    button_updown_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .SATURATE(1'b1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A press is accepted once the synchronised (2-cycle delayed) button has
    // shown the opposite level for N consecutive cycles; the count reacts two
    // cycles after acceptance.
    bit hist_u[$];
    bit hist_d[$];
    bit lvl_u, lvl_d;
    int due_u[$];
    int due_d[$];
    int cyc = 0;
    int exp_cw, exp_cs;
    bit exp_ue, exp_de, exp_ww, exp_ws;
    bit now_u, now_d;

    function automatic bit accepts(input bit h[$], input bit lvl);
        int idx;
        bit smp;
        for (int i = 0; i < N; i++) begin
            idx = h.size() - 3 - i;
            smp = (idx >= 0) ? h[idx] : 1'b0;
            if (smp == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hist_u.delete(); hist_d.delete();
            due_u.delete();  due_d.delete();
            lvl_u = 0; lvl_d = 0;
            exp_cw = 0; exp_cs = 0;
            exp_ue = 0; exp_de = 0; exp_ww = 0; exp_ws = 0;
        end else begin
            now_u = (due_u.size() > 0 && due_u[0] == cyc);
            now_d = (due_d.size() > 0 && due_d[0] == cyc);
            if (now_u) void'(due_u.pop_front());
            if (now_d) void'(due_d.pop_front());
            exp_ue = now_u; exp_de = now_d;
            exp_ww = 0; exp_ws = 0;
            if (now_u && !now_d) begin
                if (exp_cw == MAXV) begin exp_cw = 0; exp_ww = 1; end else exp_cw++;
                if (exp_cs == MAXV) exp_ws = 1; else exp_cs++;
            end
            if (now_d && !now_u) begin
                if (exp_cw == 0) begin exp_cw = MAXV; exp_ww = 1; end else exp_cw--;
                if (exp_cs == 0) exp_ws = 1; else exp_cs--;
            end
            hist_u.push_back(btn_up);
            hist_d.push_back(btn_dn);
            if (hist_u.size() > 16) void'(hist_u.pop_front());
            if (hist_d.size() > 16) void'(hist_d.pop_front());
            if (accepts(hist_u, lvl_u)) begin
                lvl_u = !lvl_u;
                if (lvl_u) due_u.push_back(cyc + 2);
            end
            if (accepts(hist_d, lvl_d)) begin
                lvl_d = !lvl_d;
                if (lvl_d) due_d.push_back(cyc + 2);
            end
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("w_count",  32'(bus_w.count),  32'(exp_cw));
            check("w_up_evt", 32'(bus_w.up_evt), 32'(exp_ue));
            check("w_dn_evt", 32'(bus_w.dn_evt), 32'(exp_de));
            check("w_wrap",   32'(bus_w.wrap),   32'(exp_ww));
            check("s_count",  32'(bus_s.count),  32'(exp_cs));
            check("s_up_evt", 32'(bus_s.up_evt), 32'(exp_ue));
            check("s_dn_evt", 32'(bus_s.dn_evt), 32'(exp_de));
            check("s_wrap",   32'(bus_s.wrap),   32'(exp_ws));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input bit u, input bit d, output bit su, output bit sd,
                         output bit sb, output bit sww, output bit sws);
        su = 0; sd = 0; sb = 0; sww = 0; sws = 0;
        @(negedge clk);
        btn_up = u;
        btn_dn = d;
        repeat (10) begin
            @(negedge clk);
            su  |= bus_w.up_evt;
            sd  |= bus_w.dn_evt;
            sb  |= bus_w.up_evt & bus_w.dn_evt;
            sww |= bus_w.wrap;
            sws |= bus_s.wrap;
        end
        btn_up = 0;
        btn_dn = 0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        bit up;
        bit dn;
        int reps;
        int exp_w;
        int exp_s;
        bit wrap_w;
        bit wrap_s;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit su, sd, sb, sww, sws;
        int n_evt, pos;

        vecs[0] = '{1, 0,   9,  10,  10, 0, 0};
        vecs[1] = '{1, 1,   1,  10,  10, 0, 0};
        vecs[2] = '{1, 0, 245, 255, 255, 0, 0};
        vecs[3] = '{1, 0,   1,   0, 255, 1, 1};
        vecs[4] = '{0, 1,   1, 255, 254, 1, 0};
        vecs[5] = '{0, 1, 254,   1,   0, 0, 0};
        vecs[6] = '{0, 1,   1,   0,   0, 0, 1};
        vecs[7] = '{1, 0,   5,   5,   5, 0, 0};

        // Reset, then idle
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_on = 1;
        check("reset_count", 32'(bus_w.count), 32'd0);
        check("reset_pulses", 32'({bus_w.up_evt, bus_w.dn_evt, bus_w.wrap}), 32'd0);
        repeat (100) @(negedge clk);
        check("idle_count", 32'(bus_w.count), 32'd0);

        // Held press: one event, 2+N+2 cycles after the edge
        n_evt = 0; pos = 0;
        btn_up = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus_w.up_evt) begin n_evt++; pos = i; end
        end
        check("held_evt_count", 32'(n_evt), 32'd1);
        check("held_evt_pos", 32'(pos), 32'(2 + N + 2));
        check("held_count", 32'(bus_w.count), 32'd1);
        btn_up = 0;
        repeat (10) @(negedge clk);

        // Bounce shorter than the debounce window
        n_evt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) btn_up = ~btn_up;
            @(negedge clk);
            n_evt += int'(bus_w.up_evt);
        end
        btn_up = 0;
        repeat (12) begin @(negedge clk); n_evt += int'(bus_w.up_evt); end
        check("bounce_evt", 32'(n_evt), 32'd0);
        check("bounce_count", 32'(bus_w.count), 32'd1);

        // Table of press sequences, including simultaneous and wrap/clamp cases
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) press(vecs[v].up, vecs[v].dn, su, sd, sb, sww, sws);
            check($sformatf("vec%0d_count_w", v), 32'(bus_w.count), 32'(vecs[v].exp_w));
            check($sformatf("vec%0d_count_s", v), 32'(bus_s.count), 32'(vecs[v].exp_s));
            check($sformatf("vec%0d_wrap_w", v), 32'(sww), 32'(vecs[v].wrap_w));
            check($sformatf("vec%0d_wrap_s", v), 32'(sws), 32'(vecs[v].wrap_s));
            check($sformatf("vec%0d_up_evt", v), 32'(su), 32'(vecs[v].up));
            check($sformatf("vec%0d_dn_evt", v), 32'(sd), 32'(vecs[v].dn));
            check($sformatf("vec%0d_both", v), 32'(sb), 32'(vecs[v].up & vecs[v].dn));
        end

        // Reset mid-debounce with the button held through it
        @(negedge clk);
        btn_up = 1;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_count", 32'(bus_w.count), 32'd0);
        n_evt = 0; pos = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus_w.up_evt) begin n_evt++; pos = i; end
        end
        check("midrst_evts", 32'(n_evt), 32'd1);
        check("midrst_pos", 32'(pos), 32'(2 + N + 2));
        check("midrst_count_after", 32'(bus_w.count), 32'd1);
        btn_up = 0;
        repeat (10) @(negedge clk);

        // Random buttons and occasional resets against the model
        for (int seg = 0; seg < 400; seg++) begin
            @(negedge clk);
            btn_up = 1'($urandom_range(0, 1));
            btn_dn = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            rst = 0;
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        btn_up = 0;
        btn_dn = 0;
        repeat (20) @(negedge clk);

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
